fp_serial_align: RTL and testbench

Multi-cycle operand alignment unit for the floating-point adder datapath. It accepts two IEEE-754 single-precision operands over a valid/ready handshake. It shifts the smaller-exponent significand right one step per clock until both exponents match, collecting guard/round/sticky bits along the way. It presents the aligned pair downstream over a second valid/ready handshake. It performs the right-shift counterpart of the normalize stage and feeds the ALU stage on area-constrained builds where a combinational barrel shifter is not wanted.

---
 rtl/fp_serial_align_pkg.sv | 20 ++
 rtl/fp_serial_align_if.sv | 31 +++
 rtl/fp_serial_align_unpack.sv | 18 +
 rtl/fp_serial_align.sv | 129 ++++++++++++
 tb/tb_fp_serial_align.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/fp_serial_align_pkg.sv
// Shared fp32 types and constants for the serial alignment datapath.
package fp_serial_align_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    localparam int         EXP_BIAS    = 127;
    localparam logic [7:0] EXP_SPECIAL = 8'hFF;
    localparam int         MANT_W      = 27;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } align_state_t;

endpackage

// File: rtl/fp_serial_align_if.sv
// Operand-in / aligned-pair-out handshake bundle for fp_serial_align.
interface fp_serial_align_if;
    import fp_serial_align_pkg::*;

    logic              in_valid;
    logic              in_ready;
    fp32_t             a;
    fp32_t             b;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_exp;
    logic [MANT_W-1:0] out_mant_big;
    logic [MANT_W-1:0] out_mant_small;
    logic              out_sign_big;
    logic              out_sign_small;
    logic              out_swapped;
    logic              out_special;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out_exp, out_mant_big, out_mant_small,
               out_sign_big, out_sign_small, out_swapped, out_special
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out_exp, out_mant_big, out_mant_small,
               out_sign_big, out_sign_small, out_swapped, out_special
    );

endinterface

// File: rtl/fp_serial_align_unpack.sv
// Combinational fp32 field decode: hidden bit, effective exponent, Inf/NaN flag.
module fp_unpack
    import fp_serial_align_pkg::*;
(
    input  fp32_t      op_i,
    output logic       hidden_o,
    output logic [7:0] exp_eff_o,
    output logic       special_o
);

    always_comb begin
        hidden_o  = (op_i.exp != 8'd0);
        // Denormals share the scale of exponent 1.
        exp_eff_o = (op_i.exp == 8'd0) ? 8'd1 : op_i.exp;
        special_o = (op_i.exp == EXP_SPECIAL);
    end

endmodule

// File: rtl/fp_serial_align.sv
// Serial right-shift alignment of two fp32 significands with guard/round/sticky.
module fp_serial_align
    import fp_serial_align_pkg::*;
#(
    parameter int STEP  = 1,
    parameter int MAXSH = 27
) (
    input  logic              clk,
    input  logic              rst_n,
    fp_serial_align_if.slave  bus
);

    align_state_t      state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        exp_q, exp_d;
    logic [MANT_W-1:0] mant_big_q, mant_big_d;
    logic [MANT_W-1:0] mant_small_q, mant_small_d;
    logic              sign_big_q, sign_big_d;
    logic              sign_small_q, sign_small_d;
    logic              swapped_q, swapped_d;
    logic              special_q, special_d;
    logic [7:0]        rem_q, rem_d;

    logic              hid_a, hid_b, spec_a, spec_b;
    logic [7:0]        exp_a, exp_b;
    logic              swap_c, accept_c, fire_out_c, special_c;
    logic [7:0]        diff_c, dcnt_c, step_c;
    logic [MANT_W-1:0] sig_a_c, sig_b_c, shifted_c;

    fp_unpack u_unpack_a (.op_i(bus.a), .hidden_o(hid_a), .exp_eff_o(exp_a), .special_o(spec_a));
    fp_unpack u_unpack_b (.op_i(bus.b), .hidden_o(hid_b), .exp_eff_o(exp_b), .special_o(spec_b));

    always_comb begin
        sig_a_c    = {hid_a, bus.a.frac, 3'b000};
        sig_b_c    = {hid_b, bus.b.frac, 3'b000};
        swap_c     = (exp_b > exp_a);
        diff_c     = swap_c ? (exp_b - exp_a) : (exp_a - exp_b);
        dcnt_c     = (diff_c > 8'(MAXSH)) ? 8'(MAXSH) : diff_c;
        special_c  = spec_a | spec_b;
        accept_c   = bus.in_valid && (state_q == IDLE);
        fire_out_c = out_valid_q && bus.out_ready;
        step_c     = (rem_q < 8'(STEP)) ? rem_q : 8'(STEP);
    end

    // One-bit stages chained STEP deep; each folds the bit leaving bit 0 into the sticky.
    always_comb begin
        shifted_c = mant_small_q;
        for (int i = 0; i < STEP; i++) begin
            if (8'(i) < step_c) begin
                shifted_c = {1'b0, shifted_c[MANT_W-1:2], shifted_c[1] | shifted_c[0]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            exp_q        <= '0;
            mant_big_q   <= '0;
            mant_small_q <= '0;
            sign_big_q   <= 1'b0;
            sign_small_q <= 1'b0;
            swapped_q    <= 1'b0;
            special_q    <= 1'b0;
            rem_q        <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            exp_q        <= exp_d;
            mant_big_q   <= mant_big_d;
            mant_small_q <= mant_small_d;
            sign_big_q   <= sign_big_d;
            sign_small_q <= sign_small_d;
            swapped_q    <= swapped_d;
            special_q    <= special_d;
            rem_q        <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = (special_c || dcnt_c == 8'd0) ? DONE : SHIFT;
            SHIFT:   if (rem_q <= 8'(STEP)) state_d = DONE;
            DONE:    if (fire_out_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state; out_valid lags entry into DONE by one registered cycle.
    always_comb begin
        out_valid_d  = (state_q == DONE) && !fire_out_c;
        exp_d        = exp_q;
        mant_big_d   = mant_big_q;
        mant_small_d = mant_small_q;
        sign_big_d   = sign_big_q;
        sign_small_d = sign_small_q;
        swapped_d    = swapped_q;
        special_d    = special_q;
        rem_d        = rem_q;
        if (accept_c) begin
            exp_d        = swap_c ? exp_b : exp_a;
            mant_big_d   = swap_c ? sig_b_c : sig_a_c;
            mant_small_d = swap_c ? sig_a_c : sig_b_c;
            sign_big_d   = swap_c ? bus.b.sign : bus.a.sign;
            sign_small_d = swap_c ? bus.a.sign : bus.b.sign;
            swapped_d    = swap_c;
            special_d    = special_c;
            rem_d        = special_c ? 8'd0 : dcnt_c;
        end else if (state_q == SHIFT) begin
            mant_small_d = shifted_c;
            rem_d        = rem_q - step_c;
        end
    end

    always_comb begin
        bus.in_ready       = (state_q == IDLE);
        bus.out_valid      = out_valid_q;
        bus.out_exp        = exp_q;
        bus.out_mant_big   = mant_big_q;
        bus.out_mant_small = mant_small_q;
        bus.out_sign_big   = sign_big_q;
        bus.out_sign_small = sign_small_q;
        bus.out_swapped    = swapped_q;
        bus.out_special    = special_q;
    end

endmodule

// File: tb/tb_fp_serial_align.sv
// Directed bench for fp_serial_align: STEP=1 and STEP=2 instances, hand-computed vectors.
module tb_fp_serial_align;
    import fp_serial_align_pkg::*;

    logic clk;
    logic rst_n;
    logic sel;
    int   n_checks;
    int   n_fail;

    fp_serial_align_if u_if0 ();
    fp_serial_align_if u_if1 ();

    fp_serial_align #(.STEP(1), .MAXSH(27)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(u_if0.slave));
    fp_serial_align #(.STEP(2), .MAXSH(27)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(u_if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire              m_in_ready   = sel ? u_if1.in_ready       : u_if0.in_ready;
    wire              m_out_valid  = sel ? u_if1.out_valid      : u_if0.out_valid;
    wire [7:0]        m_exp        = sel ? u_if1.out_exp        : u_if0.out_exp;
    wire [MANT_W-1:0] m_mb         = sel ? u_if1.out_mant_big   : u_if0.out_mant_big;
    wire [MANT_W-1:0] m_ms         = sel ? u_if1.out_mant_small : u_if0.out_mant_small;
    wire              m_sb         = sel ? u_if1.out_sign_big   : u_if0.out_sign_big;
    wire              m_ss         = sel ? u_if1.out_sign_small : u_if0.out_sign_small;
    wire              m_sw         = sel ? u_if1.out_swapped    : u_if0.out_swapped;
    wire              m_sp         = sel ? u_if1.out_special    : u_if0.out_special;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic drive_in(input logic v, input logic [31:0] av, input logic [31:0] bv);
        if (sel) begin
            u_if1.in_valid = v; u_if1.a = av; u_if1.b = bv;
        end else begin
            u_if0.in_valid = v; u_if0.a = av; u_if0.b = bv;
        end
    endtask

    task automatic check_data(input logic [7:0] e, input logic [26:0] mb, input logic [26:0] ms,
                              input logic sb, input logic ss, input logic sw, input logic sp);
        check_eq("out_exp",        32'(m_exp), 32'(e));
        check_eq("out_mant_big",   32'(m_mb),  32'(mb));
        check_eq("out_mant_small", 32'(m_ms),  32'(ms));
        check_eq("out_sign_big",   32'(m_sb),  32'(sb));
        check_eq("out_sign_small", 32'(m_ss),  32'(ss));
        check_eq("out_swapped",    32'(m_sw),  32'(sw));
        check_eq("out_special",    32'(m_sp),  32'(sp));
    endtask

    // Called 1 time unit after a rising edge with the DUT idle.
    task automatic run_case(input logic s, input logic [31:0] av, input logic [31:0] bv, input int lat_exp,
                            input logic [7:0] e, input logic [26:0] mb, input logic [26:0] ms,
                            input logic sb, input logic ss, input logic sw, input logic sp,
                            input int hold);
        int lat;
        sel = s;
        drive_in(1'b1, av, bv);
        #1;
        check_eq("in_ready_idle", 32'(m_in_ready), 32'd1);
        @(posedge clk);
        #1;
        drive_in(1'b0, 32'd0, 32'd0);
        lat = 1;
        while (!m_out_valid && lat <= 64) begin
            @(posedge clk);
            #1;
            if (!m_out_valid) lat++;
        end
        check_eq("latency", 32'(lat), 32'(lat_exp));
        check_data(e, mb, ms, sb, ss, sw, sp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq("hold_out_valid", 32'(m_out_valid), 32'd1);
            check_eq("hold_in_ready",  32'(m_in_ready),  32'd0);
            check_data(e, mb, ms, sb, ss, sw, sp);
        end
        u_if0.out_ready = 1'b1;
        u_if1.out_ready = 1'b1;
        @(posedge clk);
        #1;
        u_if0.out_ready = 1'b0;
        u_if1.out_ready = 1'b0;
        check_eq("post_out_valid", 32'(m_out_valid), 32'd0);
        check_eq("post_in_ready",  32'(m_in_ready),  32'd1);
        $display("txn dut%0d a=%h b=%h lat=%0d exp=%h mb=%h ms=%h sw=%0d sp=%0d",
                 s, av, bv, lat, m_exp, m_mb, m_ms, m_sw, m_sp);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sel      = 1'b0;
        rst_n    = 1'b0;
        u_if0.in_valid = 1'b0; u_if0.a = '0; u_if0.b = '0; u_if0.out_ready = 1'b0;
        u_if1.in_valid = 1'b0; u_if1.a = '0; u_if1.b = '0; u_if1.out_ready = 1'b0;

        #12;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check_eq("rst_in_ready",  32'(m_in_ready),  32'd1);
            check_eq("rst_out_valid", 32'(m_out_valid), 32'd0);
            check_data(8'h00, 27'h0, 27'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1.0 + 1.0: equal exponents
        run_case(1'b0, 32'h3F800000, 32'h3F800000, 1, 8'h7F, 27'h4000000, 27'h4000000, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        // -1.245 + 2.753: b larger, one-bit shift
        run_case(1'b0, 32'hBF9F5C29, 32'h40303127, 2, 8'h80, 27'h5818938, 27'h27D70A4, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        // 4.0 + 1.0, STEP=1 then STEP=2
        run_case(1'b0, 32'h40800000, 32'h3F800000, 3, 8'h81, 27'h4000000, 27'h1000000, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_case(1'b1, 32'h40800000, 32'h3F800000, 2, 8'h81, 27'h4000000, 27'h1000000, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        // 16.0 + 1.00000060 on STEP=2: d=4, sticky set by the second step
        run_case(1'b1, 32'h41800000, 32'h3F800005, 3, 8'h83, 27'h4000000, 27'h0400003, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        // 2^30 + 1.0: d clamped to 27, only sticky remains
        run_case(1'b0, 32'h4E800000, 32'h3F800000, 28, 8'h9D, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        // two denormals: effective exponent 1, hidden bit 0
        run_case(1'b0, 32'h00000001, 32'h00000002, 1, 8'h01, 27'h0000008, 27'h0000010, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        // +Inf + 1.0: no shift, held 5 cycles with out_ready low
        run_case(1'b0, 32'h7F800000, 32'h3F800000, 1, 8'hFF, 27'h4000000, 27'h4000000, 1'b0, 1'b0, 1'b0, 1'b1, 5);

        // Abort a long shift with reset at cycle 10
        sel = 1'b0;
        drive_in(1'b1, 32'h4E800000, 32'h3F800000);
        @(posedge clk);
        #1;
        drive_in(1'b0, 32'd0, 32'd0);
        repeat (9) @(posedge clk);
        #1;
        check_eq("abort_pre_in_ready",  32'(m_in_ready),  32'd0);
        check_eq("abort_pre_out_valid", 32'(m_out_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("abort_in_ready",  32'(m_in_ready),  32'd1);
        check_eq("abort_out_valid", 32'(m_out_valid), 32'd0);
        check_eq("abort_out_exp",   32'(m_exp),       32'd0);
        $display("txn dut0 reset abort in_ready=%0d out_valid=%0d", m_in_ready, m_out_valid);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_case(1'b0, 32'h3F800000, 32'h3F800000, 1, 8'h7F, 27'h4000000, 27'h4000000, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
